v6510_port_fade: RTL and testbench
==================================

V6510_PORT_FADE -- requirements
Module: v6510_port_fade

Interface
REQ-001 Parameter FADE_CYCLES, default 200000: number of phi2 cycles a masked input bit retains its last driven value.
REQ-002 Parameter FADE_MASK, default 8'hC0: bits that fade when input; unmasked bits read pin_in (bits 0-5) or 0 (bits 6-7) when input.
REQ-003 phi2  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ddr  input  8  port data-direction register value; 1 = output.
REQ-006 data  input  8  port data register value.
REQ-007 pin_in  input  6  sampled port pins 0-5.
REQ-008 read_val  output  8  registered value the CPU reads at address $0001.
REQ-009 fading  output  8  registered; bit i = 1 while bit i is in HOLD.
REQ-010 fade_event  output  1  registered; one-cycle pulse when any bit goes HOLD->FADED.

Function
REQ-011 Each bit i with FADE_MASK[i]=1 SHALL keep a 3-state FSM: DRIVEN, HOLD, FADED; a hold bit; and a counter of width ceil(log2(FADE_CYCLES+1)).
REQ-012 Any state with ddr[i]=1 at an edge -> DRIVEN; hold[i] <= data[i]; counter <= 0.
REQ-013 DRIVEN with ddr[i]=0 -> HOLD if hold[i]=1 (counter <= 0); -> FADED directly if hold[i]=0.
REQ-014 HOLD with ddr[i]=0: counter increments each edge; at the edge where counter = FADE_CYCLES-1 -> FADED, hold[i] <= 0, counter <= 0.
REQ-015 HOLD therefore lasts exactly FADE_CYCLES edges after the edge that entered it; FADED persists until ddr[i]=1.
REQ-016 Writes to data[i] while ddr[i]=0 SHALL NOT change hold[i].
REQ-017 ddr[i] returning to 1 during HOLD, including on the terminal edge, SHALL take priority: -> DRIVEN, no fade_event for that bit.
REQ-018 read_val[i], one-cycle latency from inputs: ddr[i]=1 -> data[i]; else masked bit -> hold[i] as updated on that edge, i.e. HOLD -> 1, FADED -> 0; else unmasked -> pin_in[i] (i<6) or 0 (i>=6).
REQ-019 fading[i] = 1 exactly when bit i's next state is HOLD; unmasked bits always 0.
REQ-020 fade_event SHALL be 1 for the single cycle after an edge on which at least one bit made a HOLD->FADED transition; simultaneous bits yield one pulse.
REQ-021 Counters SHALL saturate logically via REQ-014 and never wrap.

Reset
REQ-022 reset=1 at an edge: all masked bits FADED, hold=0, counters=0; read_val=8'h00, fading=8'h00, fade_event=0.
REQ-023 reset SHALL override all other inputs, including during HOLD; the first edge after release evaluates inputs normally.

Configuration
REQ-024 Macro PORT_FADE_EN: when defined, REQ-011..REQ-021 apply.
REQ-025 When PORT_FADE_EN is undefined: no FSMs or counters; masked input bits read 0 one cycle after ddr[i]=0; fading=0 and fade_event=0 always.

Verification
REQ-026 FADE_CYCLES=10, reset, then ddr=8'hFF and data=8'hC0 for 1 cycle, then ddr=8'h00 -> read_val[7:6]=2'b11 for 10 cycles, then 2'b00; fade_event pulses once; fading=8'hC0 during HOLD.
REQ-027 ddr=8'hFF with data=8'h40, then ddr=8'h00 -> bit 7 FADED immediately (read 0); bit 6 holds 1 for 10 cycles.
REQ-028 During HOLD, set ddr[7]=1 on cycle 10 (terminal edge) -> bit 7 DRIVEN, read_val[7]=data[7], no fade_event for bit 7.
REQ-029 During HOLD, change data to 8'h00 with ddr=8'h00 -> read_val[7:6] stays 2'b11 until fade.
REQ-030 ddr=8'h00, pin_in=6'b101010 -> read_val[5:0]=6'b101010 after one cycle; assert reset mid-HOLD -> all outputs 0 next cycle.
REQ-031 Build without PORT_FADE_EN, repeat REQ-026 -> read_val[7:6]=2'b00 one cycle after ddr=8'h00; fade_event never asserts.

Source files
------------

// File: rtl/v6510_port_fade.sv
// 6510 processor-port read-back with capacitive fade on floating input bits.
// The fade FSMs and counters are built only when PORT_FADE_EN is defined; otherwise masked input bits read 0.
module v6510_port_fade #(
    parameter int unsigned FADE_CYCLES = 200000,
    parameter logic [7:0]  FADE_MASK   = 8'hC0
) (
    input  logic       phi2,
    input  logic       reset,
    input  logic [7:0] ddr,
    input  logic [7:0] data,
    input  logic [5:0] pin_in,
    output logic [7:0] read_val,
    output logic [7:0] fading,
    output logic       fade_event
);

    // A zero-length hold window has no meaning; refuse to elaborate it.
    if (FADE_CYCLES < 1) begin : g_bad_cycles
        $error("FADE_CYCLES must be at least 1");
    end

`ifdef PORT_FADE_EN
    localparam int CW = $clog2(FADE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(FADE_CYCLES - 1);

    localparam logic [1:0] ST_DRIVEN = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_FADED  = 2'd2;
`endif

    logic [7:0] read_next;
    logic [7:0] fading_next;
    logic [7:0] fade_hit;

    logic [7:0] read_val_reg;
    logic [7:0] fading_reg;
    logic       fade_event_reg;

    for (genvar gi = 0; gi < 8; gi = gi + 1) begin : g_bit
        if (FADE_MASK[gi]) begin : g_masked
`ifdef PORT_FADE_EN
            logic [1:0]    state_reg, state_next;
            logic          hold_reg, hold_next;
            logic [CW-1:0] count_reg, count_next;
            logic          hit_next;

            always_comb begin
                state_next = state_reg;
                hold_next  = hold_reg;
                count_next = count_reg;
                hit_next   = 1'b0;
                if (ddr[gi]) begin
                    // Driving the pin always wins, even on the terminal hold edge.
                    state_next = ST_DRIVEN;
                    hold_next  = data[gi];
                    count_next = '0;
                end else begin
                    case (state_reg)
                        ST_DRIVEN: begin
                            count_next = '0;
                            state_next = hold_reg ? ST_HOLD : ST_FADED;
                        end
                        ST_HOLD: begin
                            if (count_reg == LAST_COUNT) begin
                                state_next = ST_FADED;
                                hold_next  = 1'b0;
                                count_next = '0;
                                hit_next   = 1'b1;
                            end else begin
                                count_next = count_reg + CW'(1);
                            end
                        end
                        default: begin
                            state_next = ST_FADED;
                            hold_next  = 1'b0;
                            count_next = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge phi2) begin
                if (reset) begin
                    state_reg <= ST_FADED;
                    hold_reg  <= 1'b0;
                    count_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    count_reg <= count_next;
                end
            end

            assign read_next[gi]   = hold_next;
            assign fading_next[gi] = (state_next == ST_HOLD);
            assign fade_hit[gi]    = hit_next;
`else
            assign read_next[gi]   = ddr[gi] & data[gi];
            assign fading_next[gi] = 1'b0;
            assign fade_hit[gi]    = 1'b0;
`endif
        end else begin : g_plain
            if (gi < 6) begin : g_pin
                assign read_next[gi] = ddr[gi] ? data[gi] : pin_in[gi];
            end else begin : g_nopin
                assign read_next[gi] = ddr[gi] & data[gi];
            end
            assign fading_next[gi] = 1'b0;
            assign fade_hit[gi]    = 1'b0;
        end
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            read_val_reg   <= 8'h00;
            fading_reg     <= 8'h00;
            fade_event_reg <= 1'b0;
        end else begin
            read_val_reg   <= read_next;
            fading_reg     <= fading_next;
            fade_event_reg <= |fade_hit;
        end
    end

    assign read_val   = read_val_reg;
    assign fading     = fading_reg;
    assign fade_event = fade_event_reg;

endmodule

// File: tb/tb_v6510_port_fade.sv
// Directed bench for v6510_port_fade with FADE_CYCLES=10; expectations follow PORT_FADE_EN.
module tb_v6510_port_fade;

`ifdef PORT_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    logic       phi2 = 1'b0;
    logic       reset;
    logic [7:0] ddr;
    logic [7:0] data;
    logic [5:0] pin_in;
    logic [7:0] read_val;
    logic [7:0] fading;
    logic       fade_event;

    int checks_total  = 0;
    int checks_passed = 0;

    v6510_port_fade #(
        .FADE_CYCLES(10),
        .FADE_MASK  (8'hC0)
    ) dut (
        .phi2      (phi2),
        .reset     (reset),
        .ddr       (ddr),
        .data      (data),
        .pin_in    (pin_in),
        .read_val  (read_val),
        .fading    (fading),
        .fade_event(fade_event)
    );

    always #5 phi2 = ~phi2;

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ddr = 8'hFF; data = 8'hFF; pin_in = 6'h3F;
        step();
        checks_total++;
        if (read_val !== 8'h00) $display("FAIL reset_read_val: got %h expected 00", read_val);
        else checks_passed++;
        checks_total++;
        if (fading !== 8'h00) $display("FAIL reset_fading: got %h expected 00", fading);
        else checks_passed++;
        checks_total++;
        if (fade_event !== 1'b0) $display("FAIL reset_fade_event: got %b expected 0", fade_event);
        else checks_passed++;
        $display("reset: read_val=%h fading=%h fade_event=%b", read_val, fading, fade_event);
    endtask

    task automatic test_pins();
        reset = 1'b0; ddr = 8'h00; data = 8'hFF; pin_in = 6'b101010;
        step();
        checks_total++;
        if (read_val !== 8'h2A) $display("FAIL pins_read_val: got %h expected 2a", read_val);
        else checks_passed++;
        checks_total++;
        if (fading !== 8'h00) $display("FAIL pins_fading: got %h expected 00", fading);
        else checks_passed++;
        $display("pins: pin_in=%b read_val=%h", pin_in, read_val);
        ddr = 8'hFF; data = 8'hA5;
        step();
        checks_total++;
        if (read_val !== 8'hA5) $display("FAIL drive_read_val: got %h expected a5", read_val);
        else checks_passed++;
        $display("drive: data=%h read_val=%h", data, read_val);
    endtask

    // Drive drive_data with all outputs, release, then watch 12 edges with hold_data on the data register.
    task automatic test_fade_hold(input logic [7:0] drive_data, input logic [7:0] hold_data);
        logic [7:0] held;
        logic [7:0] exp_rv;
        logic       exp_ev;
        held = drive_data & 8'hC0;
        ddr = 8'hFF; data = drive_data; pin_in = 6'h00;
        step();
        checks_total++;
        if (read_val !== drive_data) $display("FAIL hold_drive: got %h expected %h", read_val, drive_data);
        else checks_passed++;
        ddr = 8'h00; data = hold_data;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_rv = (FADE_ON && k < 10) ? held : 8'h00;
            exp_ev = FADE_ON && (k == 10) && (held != 8'h00);
            checks_total++;
            if (read_val !== exp_rv) $display("FAIL hold_read_val k=%0d: got %h expected %h", k, read_val, exp_rv);
            else checks_passed++;
            checks_total++;
            if (fading !== exp_rv) $display("FAIL hold_fading k=%0d: got %h expected %h", k, fading, exp_rv);
            else checks_passed++;
            checks_total++;
            if (fade_event !== exp_ev) $display("FAIL hold_fade_event k=%0d: got %b expected %b", k, fade_event, exp_ev);
            else checks_passed++;
            $display("hold k=%0d: read_val=%h fading=%h fade_event=%b", k, read_val, fading, fade_event);
        end
    endtask

    // Hold both bits, then re-drive on the terminal edge with term_ddr/term_data.
    task automatic test_terminal(input logic [7:0] term_ddr, input logic [7:0] term_data,
                                 input logic [7:0] exp_rv, input logic fade_ev_if_on);
        logic [7:0] exp_hold;
        logic       exp_ev;
        exp_hold = FADE_ON ? 8'hC0 : 8'h00;
        ddr = 8'hFF; data = 8'hC0; pin_in = 6'h00;
        step();
        ddr = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step();
            checks_total++;
            if (read_val !== exp_hold) $display("FAIL term_hold k=%0d: got %h expected %h", k, read_val, exp_hold);
            else checks_passed++;
        end
        ddr = term_ddr; data = term_data;
        step();
        exp_ev = FADE_ON && fade_ev_if_on;
        checks_total++;
        if (read_val !== exp_rv) $display("FAIL term_read_val: got %h expected %h", read_val, exp_rv);
        else checks_passed++;
        checks_total++;
        if (fading !== 8'h00) $display("FAIL term_fading: got %h expected 00", fading);
        else checks_passed++;
        checks_total++;
        if (fade_event !== exp_ev) $display("FAIL term_fade_event: got %b expected %b", fade_event, exp_ev);
        else checks_passed++;
        $display("terminal ddr=%h: read_val=%h fade_event=%b", term_ddr, read_val, fade_event);
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] exp_rv;
        ddr = 8'hFF; data = 8'hC0; pin_in = 6'b101010;
        step();
        ddr = 8'h00; data = 8'h00;
        step(); step(); step();
        exp_rv = FADE_ON ? 8'hEA : 8'h2A;
        checks_total++;
        if (read_val !== exp_rv) $display("FAIL midhold_read_val: got %h expected %h", read_val, exp_rv);
        else checks_passed++;
        reset = 1'b1;
        step();
        checks_total++;
        if (read_val !== 8'h00) $display("FAIL midreset_read_val: got %h expected 00", read_val);
        else checks_passed++;
        checks_total++;
        if (fading !== 8'h00) $display("FAIL midreset_fading: got %h expected 00", fading);
        else checks_passed++;
        $display("mid-hold reset: read_val=%h fading=%h", read_val, fading);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            checks_total++;
            if (read_val !== 8'h2A) $display("FAIL postreset_read_val k=%0d: got %h expected 2a", k, read_val);
            else checks_passed++;
            checks_total++;
            if (fade_event !== 1'b0) $display("FAIL postreset_fade_event k=%0d: got %b expected 0", k, fade_event);
            else checks_passed++;
        end
        $display("post-reset: read_val=%h fading=%h", read_val, fading);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rel;
        exp_rel = FADE_ON ? 8'hC0 : 8'h00;
        pin_in = 6'h00; data = 8'hC0;
        for (int k = 0; k < 4; k++) begin
            ddr = 8'hFF;
            step();
            checks_total++;
            if (read_val !== 8'hC0) $display("FAIL b2b_drive k=%0d: got %h expected c0", k, read_val);
            else checks_passed++;
            ddr = 8'h00;
            step();
            checks_total++;
            if (read_val !== exp_rel) $display("FAIL b2b_release k=%0d: got %h expected %h", k, read_val, exp_rel);
            else checks_passed++;
            checks_total++;
            if (fading !== exp_rel) $display("FAIL b2b_fading k=%0d: got %h expected %h", k, fading, exp_rel);
            else checks_passed++;
            $display("b2b k=%0d: read_val=%h fading=%h", k, read_val, fading);
        end
    endtask

    initial begin
        test_reset();
        test_pins();
        test_fade_hold(8'hC0, 8'hC0);
        test_fade_hold(8'hC0, 8'h00);
        test_fade_hold(8'h40, 8'h00);
        test_terminal(8'hC0, 8'h40, 8'h40, 1'b0);
        test_terminal(8'h80, 8'h80, 8'h80, 1'b1);
        test_reset_mid_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
